// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock divider.
// Channel and top modules import these defaults.
package clkdiv_pkg;

    localparam int CNT_W       = 17;
    localparam int DEFAULT_DIV = 100000;
    localparam int MIN_DIV     = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow settings,
// pending flag and registered divclk/tick outputs.
module clk_div_chan
    import clkdiv_pkg::*;
#(
    parameter int W       = CNT_W,
    parameter int DEF_DIV = DEFAULT_DIV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         sync_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_div_i,
    input  logic [W-1:0] wr_high_i,
    output logic         pend_o,
    output logic         divclk_o,
    output logic         tick_o
);

    localparam logic [W-1:0] RST_DIV  = W'(DEF_DIV);
    localparam logic [W-1:0] RST_HIGH = W'(DEF_DIV / 2);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_a_q, div_a_d;
    logic [W-1:0] high_a_q, high_a_d;
    logic [W-1:0] div_s_q, div_s_d;
    logic [W-1:0] high_s_q, high_s_d;
    logic         pend_q, pend_d;
    logic         divclk_q, divclk_d;
    logic         tick_q, tick_d;
    logic         wrap, apply, level;

    always_comb begin
        div_a_d  = div_a_q;
        high_a_d = high_a_q;
        div_s_d  = div_s_q;
        high_s_d = high_s_q;
        pend_d   = pend_q;
        wrap     = en_i && (cnt_q == div_a_q - W'(1));
        // Settings only change at a period boundary, a sync or while idle
        apply    = sync_i || !en_i || wrap;
        level    = (high_a_q >= div_a_q) ? 1'b1
                 : (cnt_q >= div_a_q - high_a_q);
        if (apply && wr_i) begin
            div_a_d  = wr_div_i;
            high_a_d = wr_high_i;
            div_s_d  = wr_div_i;
            high_s_d = wr_high_i;
            pend_d   = 1'b0;
        end else if (apply && pend_q) begin
            div_a_d  = div_s_q;
            high_a_d = high_s_q;
            pend_d   = 1'b0;
        end else if (wr_i) begin
            div_s_d  = wr_div_i;
            high_s_d = wr_high_i;
            pend_d   = 1'b1;
        end
        cnt_d    = apply ? '0 : cnt_q + W'(1);
        divclk_d = en_i && level;
        tick_d   = wrap && !sync_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            div_a_q  <= RST_DIV;
            high_a_q <= RST_HIGH;
            div_s_q  <= RST_DIV;
            high_s_q <= RST_HIGH;
            pend_q   <= 1'b0;
            divclk_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_a_q  <= div_a_d;
            high_a_q <= high_a_d;
            div_s_q  <= div_s_d;
            high_s_q <= high_s_d;
            pend_q   <= pend_d;
            divclk_q <= divclk_d;
            tick_q   <= tick_d;
        end
    end

    assign pend_o   = pend_q;
    assign divclk_o = divclk_q;
    assign tick_o   = tick_q;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider: config decode,
// ready/error handling and N_CH channel instances.
module prog_clk_div
    import clkdiv_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = clkdiv_pkg::CNT_W,
    parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic [N_CH-1:0]  divclk,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0] pend;
    logic            ch_ok, div_ok, accept, good;
    logic            err_q, err_d;

    always_comb begin
        ch_ok     = 32'(cfg_ch) < N_CH;
        div_ok    = cfg_div >= CNT_W'(MIN_DIV);
        cfg_ready = !rst && !(ch_ok && pend[cfg_ch]);
        accept    = cfg_valid && cfg_ready;
        good      = accept && ch_ok && div_ok;
        err_d     = accept && !(ch_ok && div_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_chan #(
            .W       (CNT_W),
            .DEF_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en_i      (ch_en[i]),
            .sync_i    (sync),
            .wr_i      (good && (32'(cfg_ch) == i)),
            .wr_div_i  (cfg_div),
            .wr_high_i (cfg_high),
            .pend_o    (pend[i]),
            .divclk_o  (divclk[i]),
            .tick_o    (tick[i])
        );
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed scoreboard bench for prog_clk_div (DEFAULT_DIV=10).
// Stimulus pushes hand-derived per-cycle expectations; a monitor checks.
module tb_prog_clk_div;

    localparam int N_CH  = 4;
    localparam int CNT_W = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_CH-1:0]  ch_en;
    logic             sync;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_err;
    logic [N_CH-1:0]  divclk;
    logic [N_CH-1:0]  tick;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string nm;
        byte   d0, t0, d1, t1, er, rd;
    } exp_t;

    exp_t q[$];

    prog_clk_div #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_err   (cfg_err),
        .divclk    (divclk),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    function automatic byte pick(input string s, input int i);
        return (i < s.len()) ? s[i] : "-";
    endfunction

    task automatic chk(input string nm, input string fld,
                       input byte c, input logic act);
        if (c == "-") return;
        total++;
        if (act !== (c == "1")) begin
            bad++;
            $display("FAIL %s.%s got=%b want=%c", nm, fld, act, c);
        end
    endtask

    // Each pattern character is the expected value after one rising edge
    task automatic run(input string nm, input int n,
                       input string d0, input string t0,
                       input string d1, input string t1,
                       input string er, input string rd);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e.nm = $sformatf("%s[%0d]", nm, i);
            e.d0 = pick(d0, i);
            e.t0 = pick(t0, i);
            e.d1 = pick(d1, i);
            e.t1 = pick(t1, i);
            e.er = pick(er, i);
            e.rd = pick(rd, i);
            q.push_back(e);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] ch, input int dv, input int hi);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = CNT_W'(dv);
        cfg_high  = CNT_W'(hi);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "divclk0", e.d0, divclk[0]);
            chk(e.nm, "tick0",   e.t0, tick[0]);
            chk(e.nm, "divclk1", e.d1, divclk[1]);
            chk(e.nm, "tick1",   e.t1, tick[1]);
            chk(e.nm, "cfg_err", e.er, cfg_err);
            chk(e.nm, "ready",   e.rd, cfg_ready);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        ch_en     = 4'hF;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = '0;
        cfg_high  = '0;
        @(negedge clk);
        #1;
        run("reset", 3, "000", "000", "000", "000", "000", "000");
        rst = 1'b0;
        run("dflt", 20,
            "00000111110000011111", "00000000010000000001",
            "00000111110000011111", "00000000010000000001",
            "00000000000000000000", "11111111111111111111");
        // mid-period write: old period completes first
        run("pre", 3, "000", "000", "000", "000", "", "111");
        wr(0, 5, 2);
        run("wr5", 1, "0", "0", "0", "0", "0", "0");
        cfg_valid = 1'b0;
        run("hold", 6, "011111", "000001", "011111", "000001",
            "000000", "000001");
        run("new5", 10, "0001100011", "0000100001",
            "0000011111", "0000000001", "", "1111111111");
        // rejected divisor
        wr(0, 1, 0);
        run("err", 1, "0", "0", "", "", "1", "1");
        cfg_valid = 1'b0;
        run("keep", 9, "001100011", "000100001", "", "",
            "000000000", "111111111");
        // high = 0 and high > div
        wr(0, 6, 0);
        run("wr6a", 1, "0", "0", "", "", "0", "0");
        cfg_valid = 1'b0;
        run("w6a", 4, "0011", "0001", "", "", "", "0001");
        run("lo", 12, "000000000000", "000001000001", "", "", "", "");
        wr(0, 6, 7);
        run("wr6b", 1, "0", "0", "", "", "", "0");
        cfg_valid = 1'b0;
        run("w6b", 5, "00000", "00001", "", "", "", "00001");
        run("hi", 12, "111111111111", "000001000001", "", "", "", "");
        // disabled channels take writes immediately
        ch_en = 4'h0;
        run("off", 2, "00", "00", "00", "00", "", "");
        wr(0, 4, 2);
        run("wr4", 1, "0", "0", "0", "0", "0", "1");
        wr(1, 6, 3);
        run("wr6c", 1, "0", "0", "0", "0", "0", "1");
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        ch_en     = 4'h1;
        run("en0", 3, "001", "000", "000", "000", "", "");
        ch_en = 4'h3;
        run("en1", 4, "1001", "1000", "0001", "0000", "", "");
        // sync lands on ch0 wrap: tick suppressed, both restart
        sync = 1'b1;
        run("sync", 1, "1", "0", "1", "0", "", "");
        sync = 1'b0;
        run("aligned", 24,
            "001100110011001100110011", "000100010001000100010001",
            "000111000111000111000111", "000001000001000001000001",
            "", "");
        // write accepted on the wrap cycle applies at once
        run("pre3", 3, "001", "000", "", "", "", "");
        wr(0, 3, 1);
        run("wrap", 1, "1", "1", "", "", "", "1");
        cfg_valid = 1'b0;
        run("new3", 6, "001001", "001001", "", "", "", "111111");
        // reset discards a pending write
        wr(0, 7, 3);
        run("pend", 1, "0", "0", "", "", "", "0");
        cfg_valid = 1'b0;
        rst = 1'b1;
        run("rst2", 2, "00", "00", "00", "00", "00", "00");
        rst = 1'b0;
        run("rel", 10, "0000011111", "0000000001",
            "0000011111", "0000000001", "0000000000", "1111111111");
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Parameters
REQ-001 N_CH, 4, number of independent divider channels (1..16).
REQ-002 CNT_W, 17, counter/divisor width in bits.
REQ-003 DEFAULT_DIV, 100000, divisor loaded at reset (2 <= DEFAULT_DIV < 2^CNT_W).

Interface
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ch_en  in  N_CH  per-channel run enable.
REQ-007 sync  in  1  one-cycle request to phase-align all channels.
REQ-008 cfg_valid  in  1  configuration write request.
REQ-009 cfg_ready  out  1  configuration write accepted when cfg_valid & cfg_ready.
REQ-010 cfg_ch  in  clog2(N_CH) (min 1)  target channel of write.
REQ-011 cfg_div  in  CNT_W  new period in clk cycles.
REQ-012 cfg_high  in  CNT_W  new high time in clk cycles.
REQ-013 cfg_err  out  1  one-cycle pulse: accepted write rejected.
REQ-014 divclk  out  N_CH  divided clock per channel, registered.
REQ-015 tick  out  N_CH  one-cycle period-start strobe per channel, registered.

Function
REQ-016 Each channel SHALL hold active (div_a, high_a), shadow (div_s, high_s), pending flag, counter cnt.
REQ-017 Enabled channel: cnt SHALL step 0..div_a-1 then wrap to 0; period exactly div_a cycles.
REQ-018 divclk SHALL equal, one cycle late, (cnt >= div_a - high_a): low first, then high for exactly high_a cycles.
REQ-019 tick SHALL equal, one cycle late, (cnt == div_a-1) with channel enabled.
REQ-020 high_a = 0 SHALL give constant-low divclk; high_a >= div_a SHALL give constant-high divclk; tick unaffected.
REQ-021 cfg_ready SHALL be combinational: !pending[cfg_ch] and !rst.
REQ-022 Accepted write with cfg_div < 2 or cfg_ch >= N_CH SHALL pulse cfg_err next cycle and change nothing.
REQ-023 Otherwise accepted write SHALL load shadow and set pending.
REQ-024 Pending shadow SHALL copy into active and clear pending at the channel's next wrap (cnt == div_a-1), so no period is truncated.
REQ-025 Write accepted in the same cycle as that channel's wrap SHALL be applied at that wrap (bypass), pending not left set.
REQ-026 Disabled channel: cnt held 0, divclk 0, tick 0; pending shadow applied on the next cycle.
REQ-027 Re-enable SHALL restart from cnt = 0; first tick after div_a cycles.
REQ-028 sync SHALL force cnt = 0 on all channels next cycle, apply all pending shadows, suppress tick that cycle.
REQ-029 sync coincident with a write: write applied by the same sync.
REQ-030 Arithmetic in CNT_W bits; div_a - high_a computed only when high_a < div_a (no underflow).

Reset
REQ-031 rst SHALL set every cnt = 0, div_a = div_s = DEFAULT_DIV, high_a = high_s = DEFAULT_DIV/2, pending = 0.
REQ-032 rst SHALL drive divclk = 0, tick = 0, cfg_err = 0, cfg_ready = 0 while asserted.
REQ-033 rst mid-period or with pending writes SHALL discard them; counting resumes cycle after release.

Structure
REQ-034 Package clkdiv_pkg SHALL hold CNT_W, DEFAULT_DIV, MIN_DIV = 2.
REQ-035 One sub-module clk_div_chan (single channel: counter, active/shadow, pending, outputs) SHALL be instantiated N_CH times; top holds decode, cfg_ready mux, cfg_err.

Verification
REQ-036 Reset, ch_en = 1, defaults with DEFAULT_DIV=10 -> divclk 5 low/5 high, tick every 10 cycles, first tick 10 cycles after release.
REQ-037 Write ch0 div=5 high=2 mid-period -> cfg_ready[ch0] low until wrap; old 10-cycle period completes, then 0,0,0,1,1 repeating.
REQ-038 Write div=1 -> cfg_err pulse, output pattern unchanged; write high=0 and high=7 with div=6 -> constant low, constant high, tick every 6.
REQ-039 Ch0 div=4, ch1 div=6 free-running, pulse sync -> both cnt=0 next cycle, no tick that cycle, coincident ticks every 12 cycles.
REQ-040 Write landing on wrap cycle -> new period starts immediately; rst asserted with pending write -> defaults restored, pending cleared.
